// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers and the priority encoder for the interrupt controller.
package cp0_pkg;

    localparam logic [4:0] CP0_ADDR_CAUSE = 5'h0d;
    localparam logic [4:0] CP0_ADDR_EPC   = 5'h0e;
    localparam logic [4:0] CP0_ADDR_DIS   = 5'h16;
    localparam logic [4:0] CP0_ADDR_MASK  = 5'h17;

    // Highest set bit wins; returns 0 when nothing is set.
    function automatic logic [2:0] prio_enc(input logic [7:0] active);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (active[i]) idx = i[2:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl_sync_edge.sv
// One interrupt channel: two-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic rise_o
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= irq_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise_o = r_sync & ~r_prev;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: pending/mask/disable/EPC, mfc0/mtc0 access and ERET.
// Optional CP0_CAUSE_EN adds a read-only CAUSE register at 5'h0d.
module cp0_irq_ctrl #(
    parameter int                N_IRQ      = 3,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] VEC_BASE   = 32'h0000_0400,
    parameter logic [DATA_W-1:0] VEC_STRIDE = 32'h0000_0200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IRQ-1:0]  irq_i,
    input  logic              accept_i,
    input  logic [DATA_W-1:0] epc_in_i,
    input  logic              eret_i,
    input  logic              mtc0_i,
    input  logic [4:0]        addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              take_o,
    output logic [DATA_W-1:0] vector_o,
    output logic [DATA_W-1:0] epc_o
);
    import cp0_pkg::*;

    logic [N_IRQ-1:0]  r_pending;
    logic [N_IRQ-1:0]  r_mask;
    logic              r_dis;
    logic [DATA_W-1:0] r_epc;

    logic [N_IRQ-1:0]  w_rise;
    logic [N_IRQ-1:0]  w_active;
    logic [N_IRQ-1:0]  w_clr;
    logic [N_IRQ-1:0]  w_pending_nxt;
    logic [2:0]        w_winner;
    logic              w_take;
    logic              w_wr_epc;
    logic              w_wr_dis;
    logic              w_wr_mask;
    logic [DATA_W-1:0] w_rdata;

    for (genvar k = 0; k < N_IRQ; k++) begin : g_chan
        irq_sync_edge u_sync (
            .clk    (clk),
            .rst    (rst),
            .irq_i  (irq_i[k]),
            .rise_o (w_rise[k])
        );
    end

    assign w_active = r_pending & r_mask;
    assign w_winner = prio_enc(8'(w_active));
    assign w_take   = (|w_active) & ~r_dis & accept_i & ~eret_i;

    // A new edge on the channel being cleared keeps its request.
    assign w_clr         = w_take ? (N_IRQ'(1) << w_winner) : '0;
    assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;

    assign w_wr_epc  = mtc0_i && (addr_i == CP0_ADDR_EPC);
    assign w_wr_dis  = mtc0_i && (addr_i == CP0_ADDR_DIS);
    assign w_wr_mask = mtc0_i && (addr_i == CP0_ADDR_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_dis     <= 1'b0;
            r_epc     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr_mask) r_mask <= wdata_i[N_IRQ-1:0];
            if (w_take) begin
                r_epc <= epc_in_i;
                r_dis <= 1'b1;
            end else begin
                if (w_wr_epc) r_epc <= wdata_i;
                if (eret_i) r_dis <= 1'b0;
                else if (w_wr_dis) r_dis <= wdata_i[0];
            end
        end
    end

`ifdef CP0_CAUSE_EN
    logic [2:0] r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_last <= 3'd0;
        else if (w_take) r_last <= w_winner;
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (addr_i)
            CP0_ADDR_EPC:  w_rdata = r_epc;
            CP0_ADDR_DIS:  w_rdata[0] = r_dis;
            CP0_ADDR_MASK: w_rdata[N_IRQ-1:0] = r_mask;
`ifdef CP0_CAUSE_EN
            CP0_ADDR_CAUSE: begin
                w_rdata[N_IRQ-1:0] = r_pending;
                w_rdata[10:8]      = r_last;
            end
`endif
            default: ;
        endcase
    end

    assign rdata_o  = w_rdata;
    assign take_o   = w_take;
    assign vector_o = VEC_BASE + DATA_W'(w_winner) * VEC_STRIDE;
    assign epc_o    = r_epc;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Bench for cp0_irq_ctrl: request-level model checked every cycle plus directed literal checks.
module tb_cp0_irq_ctrl;

  localparam logic [31:0] VB = 32'h0000_0400;
  localparam logic [31:0] VS = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_i = '0;
  logic        accept_i = 1'b0;
  logic [31:0] epc_in_i = '0;
  logic        eret_i = 1'b0;
  logic        mtc0_i = 1'b0;
  logic [4:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        take_o;
  logic [31:0] vector_o;
  logic [31:0] epc_o;

  int checks = 0;
  int errors = 0;

  cp0_irq_ctrl #(.N_IRQ(3), .DATA_W(32), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_i    (irq_i),
    .accept_i (accept_i),
    .epc_in_i (epc_in_i),
    .eret_i   (eret_i),
    .mtc0_i   (mtc0_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .take_o   (take_o),
    .vector_o (vector_o),
    .epc_o    (epc_o)
  );

  always #5 clk = ~clk;

  // ---------------- model: requests as scheduled arrivals ----------------
  logic [2:0]  m_pending, m_mask, m_prev;
  logic        m_dis;
  logic [31:0] m_epc;
  int          m_last;
  int          m_edge;
  int          arr_q[3][$];

  task automatic m_reset();
    m_pending = '0; m_mask = '0; m_prev = '0; m_dis = 1'b0;
    m_epc = '0; m_last = 0; m_edge = 0;
    for (int k = 0; k < 3; k++) arr_q[k].delete();
  endtask

  function automatic int m_winner();
    for (int i = 2; i >= 0; i--) if (m_pending[i] && m_mask[i]) return i;
    return 0;
  endfunction

  function automatic logic m_take();
    return ((m_pending & m_mask) != 3'b000) && !m_dis && accept_i && !eret_i;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'h0e: return m_epc;
      5'h16: return {31'b0, m_dis};
      5'h17: return {29'b0, m_mask};
`ifdef CP0_CAUSE_EN
      5'h0d: return {29'b0, m_pending} | (32'(m_last) << 8);
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step();
    logic t;
    int w;
    m_edge++;
    t = m_take();
    w = m_winner();
    if (t) begin
      m_epc = epc_in_i;
      m_dis = 1'b1;
      m_pending[w] = 1'b0;
      m_last = w;
    end else begin
      if (eret_i) m_dis = 1'b0;
      else if (mtc0_i && addr_i == 5'h16) m_dis = wdata_i[0];
      if (mtc0_i && addr_i == 5'h0e) m_epc = wdata_i;
    end
    if (mtc0_i && addr_i == 5'h17) m_mask = wdata_i[2:0];
    // A rise seen at this edge becomes pending two edges later.
    for (int k = 0; k < 3; k++) begin
      if (irq_i[k] && !m_prev[k]) arr_q[k].push_back(m_edge + 2);
      m_prev[k] = irq_i[k];
      if (arr_q[k].size() > 0 && arr_q[k][0] == m_edge) begin
        void'(arr_q[k].pop_front());
        m_pending[k] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial m_reset();

  always @(posedge clk) begin
    #1;
    if (rst) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    #3;
    if (rst) m_reset();
    chk("model_take",   {31'b0, take_o}, {31'b0, m_take()});
    chk("model_vector", vector_o, VB + 32'(m_winner()) * VS);
    chk("model_epc",    epc_o, m_epc);
    chk("model_rdata",  rdata_o, m_rdata(addr_i));
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    tick();
    #2;
    chk("reset_take", {31'b0, take_o}, 32'h0);
    chk("reset_vector", vector_o, 32'h0000_0400);
    chk("reset_epc", epc_o, 32'h0);
    tick();
    rst = 1'b0;

    // 1: single request on channel 1
    mtc0_i = 1'b1; addr_i = 5'h17; wdata_i = 32'h7;
    tick();
    mtc0_i = 1'b0; irq_i = 3'b010; accept_i = 1'b1; epc_in_i = 32'h100;
    tick();
    #2 chk("t1_e1_take", {31'b0, take_o}, 32'h0);
    tick();
    #2 chk("t1_e2_take", {31'b0, take_o}, 32'h0);
    tick();
    #2 chk("t1_take", {31'b0, take_o}, 32'h1);
    chk("t1_vector", vector_o, 32'h600);
    tick();
    addr_i = 5'h16;
    #2 chk("t1_epc", epc_o, 32'h100);
    chk("t1_dis", rdata_o, 32'h1);

    // 2: simultaneous ch0/ch2, then ch0 after eret
    tick();
    eret_i = 1'b1; irq_i = 3'b000;
    tick();
    eret_i = 1'b0; irq_i = 3'b101; epc_in_i = 32'h200;
    tick();
    tick();
    #2 chk("t2_pre", {31'b0, take_o}, 32'h0);
    tick();
    #2 chk("t2_take_ch2", {31'b0, take_o}, 32'h1);
    chk("t2_vector_ch2", vector_o, 32'h800);
    tick();
    addr_i = 5'h0d; eret_i = 1'b1; epc_in_i = 32'h300;
    #2 chk("t2_eret_supp", {31'b0, take_o}, 32'h0);
    chk("t2_epc", epc_o, 32'h200);
`ifdef CP0_CAUSE_EN
    chk("t6_cause", rdata_o, 32'h0000_0201);
`else
    chk("t6_cause_off", rdata_o, 32'h0);
`endif
    tick();
    eret_i = 1'b0;
    #2 chk("t2_take_ch0", {31'b0, take_o}, 32'h1);
    chk("t2_vector_ch0", vector_o, 32'h400);
    tick();
    #2 chk("t2_epc_over", epc_o, 32'h300);

    // 3: masked request, unmasked later
    tick();
    eret_i = 1'b1; irq_i = 3'b000; mtc0_i = 1'b1; addr_i = 5'h17; wdata_i = 32'h0;
    tick();
    eret_i = 1'b0; mtc0_i = 1'b0; irq_i = 3'b010;
    tick();
    tick();
    tick();
    #2 chk("t3_masked", {31'b0, take_o}, 32'h0);
    tick();
    mtc0_i = 1'b1; wdata_i = 32'h2;
    #2 chk("t3_mask_wr", {31'b0, take_o}, 32'h0);
    tick();
    mtc0_i = 1'b0;
    #2 chk("t3_take", {31'b0, take_o}, 32'h1);
    chk("t3_vector", vector_o, 32'h600);

    // 4: stall holds request; eret suppresses take for one cycle
    tick();
    eret_i = 1'b1; irq_i = 3'b000;
    tick();
    eret_i = 1'b0; irq_i = 3'b010; accept_i = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      #2 chk("t4_stall", {31'b0, take_o}, 32'h0);
      tick();
    end
    accept_i = 1'b1;
    #2 chk("t4_accept", {31'b0, take_o}, 32'h1);
    tick();
    eret_i = 1'b1; irq_i = 3'b000;
    tick();
    eret_i = 1'b0; irq_i = 3'b010;
    tick();
    tick();
    tick();
    eret_i = 1'b1;
    #2 chk("t4_eret_supp", {31'b0, take_o}, 32'h0);
    tick();
    eret_i = 1'b0;
    #2 chk("t4_after_eret", {31'b0, take_o}, 32'h1);

    // 5: take beats mtc0 epc; async reset mid-handler
    tick();
    eret_i = 1'b1; irq_i = 3'b000;
    tick();
    eret_i = 1'b0; irq_i = 3'b010;
    tick();
    irq_i = 3'b011;
    tick();
    tick();
    mtc0_i = 1'b1; addr_i = 5'h0e; wdata_i = 32'hABC0; epc_in_i = 32'h5550;
    #2 chk("t5_take", {31'b0, take_o}, 32'h1);
    chk("t5_vector", vector_o, 32'h600);
    tick();
    mtc0_i = 1'b0; irq_i = 3'b000; addr_i = 5'h16;
    #2 chk("t5_epc_take_wins", epc_o, 32'h5550);
    chk("t5_dis", rdata_o, 32'h1);
    tick();
    rst = 1'b1;
    #1 chk("t5_rst_epc", epc_o, 32'h0);
    chk("t5_rst_dis", rdata_o, 32'h0);
    tick();
    tick();
    rst = 1'b0; mtc0_i = 1'b1; addr_i = 5'h17; wdata_i = 32'h7;
    tick();
    mtc0_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2 chk("t5_pending_lost", {31'b0, take_o}, 32'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
